// File: rtl/secded_pkg.sv
// SEC-DED code helpers: code-position mapping and reference encoder.
package secded_pkg;

   localparam int DATA_W  = 32;
   localparam int CHK_W   = 7;
   localparam int MAX_POS = DATA_W + CHK_W - 1;

   // Code position of data bit i: the i-th non-power-of-two position >= 3.
   function automatic int data_pos(input int i);
      int pos;
      pos = 3;
      for (int k = 0; k <= i; k++) begin
         while ((pos & (pos - 1)) == 0) pos++;
         if (k < i) pos++;
      end
      return pos;
   endfunction

   // Check bits for a data word: Hamming bits zero the syndrome, top bit gives even overall parity.
   function automatic logic [CHK_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
      logic [CHK_W-1:0] chk;
      int               pos;
      chk = '0;
      for (int i = 0; i < DATA_W; i++) begin
         pos = data_pos(i);
         for (int j = 0; j < CHK_W - 1; j++) begin
            if (data[i] && pos[j]) chk[j] = ~chk[j];
         end
      end
      chk[CHK_W-1] = ^{data, chk[CHK_W-2:0]};
      return chk;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of a received code word.
module secded_syndrome #(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 7
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [CHK_W-1:0]  chk_i,
   output logic [CHK_W-2:0]  syn_o,
   output logic              par_o
);
   import secded_pkg::*;

   localparam int HW = CHK_W - 1;

   logic [HW-1:0] contrib [DATA_W];
   logic [HW-1:0] syn_c;

   for (genvar i = 0; i < DATA_W; i++) begin : g_contrib
      assign contrib[i] = data_i[i] ? HW'(data_pos(i)) : '0;
   end

   // XOR of the positions of every set data and Hamming check bit.
   always_comb begin
      syn_c = '0;
      for (int i = 0; i < DATA_W; i++) syn_c = syn_c ^ contrib[i];
      for (int j = 0; j < HW; j++) begin
         if (chk_i[j]) syn_c = syn_c ^ (HW'(1) << j);
      end
   end

   assign syn_o = syn_c;
   assign par_o = ^{data_i, chk_i};

endmodule

// File: rtl/secded_decoder_pipe.sv
// Two-stage SEC-DED decoder with valid/ready on both sides and saturating CE/UE counters.
module secded_decoder_pipe #(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              corr_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CHK_W-1:0]  in_chk,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ce,
   output logic              out_ue,
   output logic [CHK_W-1:0]  out_syn,
   output logic [CNT_W-1:0]  ce_cnt,
   output logic [CNT_W-1:0]  ue_cnt,
   input  logic              cnt_clr
);
   import secded_pkg::*;

   localparam int            HW    = CHK_W - 1;
   localparam int            MAX_P = DATA_W + CHK_W - 1;
   localparam logic [HW-1:0] MAX_S = HW'(MAX_P);

   if ((2 ** HW) < (DATA_W + CHK_W)) begin : g_chk_w_too_small
      $error("secded_decoder_pipe: CHK_W too small for DATA_W");
   end

   logic              s1_v_q, s1_par_q, s1_en_q;
   logic [DATA_W-1:0] s1_data_q;
   logic [HW-1:0]     s1_syn_q;
   logic              s2_v_q, s2_ce_q, s2_ue_q;
   logic [DATA_W-1:0] s2_data_q;
   logic [CHK_W-1:0]  s2_syn_q;
   logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;

   logic [HW-1:0]     syn_w;
   logic              par_w;
   logic              s1_adv, s2_adv, out_xfer, syn_pow2;
   logic [DATA_W-1:0] flip_mask, s2_data_d;
   logic              s2_ce_d, s2_ue_d;
   logic [CHK_W-1:0]  s2_syn_d;

   assign s2_adv   = !s2_v_q | out_ready;
   assign s1_adv   = !s1_v_q | s2_adv;
   assign out_xfer = s2_v_q & out_ready;

   secded_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
      .data_i (in_data),
      .chk_i  (in_chk),
      .syn_o  (syn_w),
      .par_o  (par_w)
   );

   // S1: capture the raw word with its syndrome and correction mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s1_data_q <= '0;
         s1_syn_q  <= '0;
         s1_par_q  <= 1'b0;
         s1_en_q   <= 1'b0;
      end else if (s1_adv) begin
         s1_v_q <= in_valid;
         if (in_valid) begin
            s1_data_q <= in_data;
            s1_syn_q  <= syn_w;
            s1_par_q  <= par_w;
            s1_en_q   <= corr_en;
         end
      end
   end

   for (genvar i = 0; i < DATA_W; i++) begin : g_flip
      assign flip_mask[i] = (s1_syn_q == HW'(data_pos(i)));
   end

   // Zero also counts here: a lone overall-parity error is handled like a check-bit error.
   assign syn_pow2 = (s1_syn_q & (s1_syn_q - HW'(1))) == '0;

   // Classify the error and correct a single flipped data bit.
   always_comb begin
      s2_data_d = s1_data_q;
      s2_ce_d   = 1'b0;
      s2_ue_d   = 1'b0;
      s2_syn_d  = '0;
      if (s1_en_q) begin
         s2_syn_d = {s1_par_q, s1_syn_q};
         if (s1_par_q) begin
            if (syn_pow2) begin
               s2_ce_d = 1'b1;
            end else if (s1_syn_q > MAX_S) begin
               s2_ue_d = 1'b1;
            end else begin
               s2_ce_d   = 1'b1;
               s2_data_d = s1_data_q ^ flip_mask;
            end
         end else if (s1_syn_q != '0) begin
            s2_ue_d = 1'b1;
         end
      end
   end

   // S2: output register, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q    <= 1'b0;
         s2_data_q <= '0;
         s2_ce_q   <= 1'b0;
         s2_ue_q   <= 1'b0;
         s2_syn_q  <= '0;
      end else if (s2_adv) begin
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_data_q <= s2_data_d;
            s2_ce_q   <= s2_ce_d;
            s2_ue_q   <= s2_ue_d;
            s2_syn_q  <= s2_syn_d;
         end
      end
   end

   // Saturating event counters; clear wins over a same-cycle increment.
   always_comb begin
      ce_cnt_d = ce_cnt_q;
      ue_cnt_d = ue_cnt_q;
      if (cnt_clr) begin
         ce_cnt_d = '0;
         ue_cnt_d = '0;
      end else if (out_xfer) begin
         if (s2_ce_q && !(&ce_cnt_q)) ce_cnt_d = ce_cnt_q + CNT_W'(1);
         if (s2_ue_q && !(&ue_cnt_q)) ue_cnt_d = ue_cnt_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_cnt_q <= '0;
         ue_cnt_q <= '0;
      end else begin
         ce_cnt_q <= ce_cnt_d;
         ue_cnt_q <= ue_cnt_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_v_q;
   assign out_data  = s2_data_q;
   assign out_ce    = s2_ce_q;
   assign out_ue    = s2_ue_q;
   assign out_syn   = s2_syn_q;
   assign ce_cnt    = ce_cnt_q;
   assign ue_cnt    = ue_cnt_q;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Randomized bench for secded_decoder_pipe with a position-table reference decoder.
module tb_secded_decoder_pipe;
   import secded_pkg::*;

   localparam int CNT_W = 4;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        corr_en = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [6:0]  in_chk = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_ce, out_ue;
   logic [6:0]  out_syn;
   logic [CNT_W-1:0] ce_cnt, ue_cnt;
   logic        cnt_clr = 1'b0;

   always #5 clk = ~clk;

   secded_decoder_pipe #(.DATA_W(32), .CHK_W(7), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .corr_en(corr_en),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ce(out_ce), .out_ue(out_ue), .out_syn(out_syn),
      .ce_cnt(ce_cnt), .ue_cnt(ue_cnt), .cnt_clr(cnt_clr)
   );

   typedef struct {
      logic [31:0] d;
      logic        ce;
      logic        ue;
      logic [6:0]  syn;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   pos_tab[32];
   int   m_ce = 0;
   int   m_ue = 0;
   int   acc_cnt = 0;
   bit   drv_done = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Decode from first principles: lay the bits out by code position and apply the rule table.
   function automatic exp_t model(input logic [31:0] d, input logic [6:0] c, input logic en);
      exp_t e;
      int   s = 0;
      int   p = 0;
      e.d = d; e.ce = 0; e.ue = 0; e.syn = '0;
      if (!en) return e;
      for (int i = 0; i < 32; i++) if (d[i]) begin s ^= pos_tab[i]; p ^= 1; end
      for (int j = 0; j < 6; j++) if (c[j]) begin s ^= (1 << j); p ^= 1; end
      p ^= int'(c[6]);
      e.syn = {p[0], s[5:0]};
      if (p == 1) begin
         if (s == 0 || (s & (s - 1)) == 0) e.ce = 1;
         else if (s > 38) e.ue = 1;
         else begin
            e.ce = 1;
            for (int i = 0; i < 32; i++) if (pos_tab[i] == s) e.d[i] = ~e.d[i];
         end
      end else if (s != 0) begin
         e.ue = 1;
      end
      return e;
   endfunction

   // Scoreboard: transfers that will happen at the next rising edge are evaluated on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check_eq("ce_cnt", ce_cnt, m_ce);
         check_eq("ue_cnt", ue_cnt, m_ue);
         if (out_valid) begin
            if (q.size() == 0) begin
               check_eq("spurious_valid", out_valid, 1'b0);
            end else begin
               mon_e = q[0];
               check_eq("out_data", out_data, mon_e.d);
               check_eq("out_ce", out_ce, mon_e.ce);
               check_eq("out_ue", out_ue, mon_e.ue);
               check_eq("out_syn", out_syn, mon_e.syn);
               if (out_ready) begin
                  void'(q.pop_front());
                  if (mon_e.ce && m_ce < SAT) m_ce++;
                  if (mon_e.ue && m_ue < SAT) m_ue++;
               end
            end
         end
         if (cnt_clr) begin m_ce = 0; m_ue = 0; end
         if (in_valid && in_ready) begin
            q.push_back(model(in_data, in_chk, corr_en));
            acc_cnt++;
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic [6:0] c, input logic en);
      bit acc = 0;
      in_valid = 1'b1; in_data = d; in_chk = c; corr_en = en;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check_eq("send_accept", acc, 1'b1);
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && q.size() != 0; k++) begin
         @(negedge clk); #1;
      end
      check_eq("drain_empty", q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic pulse_clr();
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [38:0] cw;
      int          p = 3;
      for (int i = 0; i < 32; i++) begin
         while ((p & (p - 1)) == 0) p++;
         pos_tab[i] = p;
         p++;
      end

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_out_data", out_data, 32'h0);
      check_eq("rst_ce_cnt", ce_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: empty pipe, one word appears one cycle after acceptance and transfers on the second edge.
      d = $urandom;
      send(d, secded_encode(d), 1'b1);
      @(negedge clk);
      check_eq("lat_s1_only", out_valid, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("lat_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
      drain();

      // Clean stream.
      for (int n = 0; n < 100; n++) begin
         d = $urandom;
         send(d, secded_encode(d), 1'b1);
      end
      drain();
      check_eq("clean_ce_cnt", ce_cnt, 0);
      check_eq("clean_ue_cnt", ue_cnt, 0);

      // Single data flip.
      pulse_clr();
      send(32'hDEADBEEF ^ (32'h1 << 17), secded_encode(32'hDEADBEEF), 1'b1);
      drain();
      check_eq("sbe_ce_cnt", ce_cnt, 1);

      // Hamming check bit and overall parity flips.
      pulse_clr();
      send(32'h0, secded_encode(32'h0) ^ 7'h04, 1'b1);
      send(32'h0, secded_encode(32'h0) ^ 7'h40, 1'b1);
      drain();
      check_eq("chk_ce_cnt", ce_cnt, 2);
      check_eq("chk_ue_cnt", ue_cnt, 0);

      // Double flip.
      pulse_clr();
      send(32'h80000001, secded_encode(32'h0), 1'b1);
      drain();
      check_eq("dbe_ue_cnt", ue_cnt, 1);

      // Backpressure: two words fill the pipe, the third waits.
      out_ready = 1'b0;
      acc_cnt = 0;
      fork
         begin
            send(32'h11111111, secded_encode(32'h11111111), 1'b1);
            send(32'h22222222 ^ 32'h8, secded_encode(32'h22222222), 1'b1);
            send(32'h33333333, secded_encode(32'h33333333), 1'b1);
         end
         begin
            repeat (4) @(negedge clk);
            check_eq("bp_in_ready", in_ready, 1'b0);
            check_eq("bp_accepted", acc_cnt, 2);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check_eq("bp_total_acc", acc_cnt, 3);

      // Reset with words in flight.
      out_ready = 1'b0;
      send(32'hA5A5A5A5, secded_encode(32'hA5A5A5A5), 1'b1);
      send(32'h5A5A5A5A, secded_encode(32'h5A5A5A5A), 1'b1);
      rst_n = 1'b0;
      q.delete();
      m_ce = 0; m_ue = 0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("mid_rst_out_valid", out_valid, 1'b0);
      check_eq("mid_rst_in_ready", in_ready, 1'b1);
      check_eq("mid_rst_out_data", out_data, 32'h0);
      check_eq("mid_rst_flags", {out_ce, out_ue, out_syn}, 9'h0);
      check_eq("mid_rst_ue_cnt", ue_cnt, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("post_rst_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;

      // Bypass word with a flipped bit passes raw and does not count.
      send(32'hCAFEF00D ^ 32'h20, secded_encode(32'hCAFEF00D), 1'b0);
      drain();
      check_eq("byp_ce_cnt", ce_cnt, 0);

      // Saturation then clear.
      for (int n = 0; n < SAT + 5; n++) begin
         d = $urandom;
         send(d ^ (32'h1 << $urandom_range(0, 31)), secded_encode(d), 1'b1);
      end
      drain();
      check_eq("sat_ce_cnt", ce_cnt, SAT);
      pulse_clr();
      check_eq("sat_clr_ce_cnt", ce_cnt, 0);

      // Random words, errors, modes, backpressure and clears.
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               d  = $urandom;
               cw = {secded_encode(d), d};
               for (int f = 0; f < int'($urandom_range(0, 2)); f++)
                  cw[$urandom_range(0, 38)] ^= 1'b1;
               send(cw[31:0], cw[38:32], ($urandom_range(0, 7) != 0));
            end
            drv_done = 1;
         end
         begin
            while (!drv_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               cnt_clr   = ($urandom_range(0, 31) == 0);
               @(posedge clk); #1;
            end
         end
      join
      out_ready = 1'b1;
      cnt_clr = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
